// File: rtl/matmul_ctrl.sv
// matmul_ctrl: i/j/k loop sequencer for the single-core matrix multiplier.
// Optional abort input enabled by defining MATMUL_CTRL_ABORT_EN.
module matmul_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_DIM    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            dim,
`ifdef MATMUL_CTRL_ABORT_EN
  input  logic                  abort,
`endif
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  ar_we,
  output logic                  br_we,
  output logic                  acc_clr,
  output logic                  acc_we,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FA,
    S_FB,
    S_LB,
    S_MAC,
    S_ST,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0] i_q, j_q, k_q, n_q;
  logic [3:0] i_d, j_d, k_d, n_d;
  logic [3:0] last;
  logic       dim_ok;
  logic       kill;

  logic [ADDR_WIDTH-1:0] addr_nx;
  logic mem_we_nx, ar_we_nx, br_we_nx;
  logic acc_clr_nx, acc_we_nx;
  logic busy_nx, done_nx, err_nx;

  logic [ADDR_WIDTH-1:0] na, ia, ja, ka, nn;

  assign last   = n_q - 4'd1;
  assign dim_ok = (dim != 4'd0) && (int'(dim) <= MAX_DIM);

`ifdef MATMUL_CTRL_ABORT_EN
  assign kill = abort && (state_q != S_IDLE) && (state_q != S_DONE);
`else
  assign kill = 1'b0;
`endif

  // State and loop counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      n_q     <= n_d;
    end
  end

  // Next state and loop-index updates
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    n_d     = n_q;
    err_nx  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          i_d = '0;
          j_d = '0;
          k_d = '0;
          if (dim_ok) begin
            n_d     = dim;
            state_d = S_CLR;
          end else begin
            err_nx  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_CLR: state_d = S_FA;
      S_FA:  state_d = S_FB;
      S_FB:  state_d = S_LB;
      S_LB:  state_d = S_MAC;
      S_MAC: begin
        if (k_q != last) begin
          k_d     = k_q + 4'd1;
          state_d = S_FA;
        end else begin
          k_d     = '0;
          state_d = S_ST;
        end
      end
      S_ST: begin
        k_d = '0;
        if (j_q != last) begin
          j_d     = j_q + 4'd1;
          state_d = S_CLR;
        end else if (i_q != last) begin
          j_d     = '0;
          i_d     = i_q + 4'd1;
          state_d = S_CLR;
        end else begin
          i_d     = '0;
          j_d     = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill) begin
      state_d = S_IDLE;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
    end
  end

  // Operand addresses from the indices of the upcoming state
  always_comb begin
    na = ADDR_WIDTH'(n_d);
    ia = ADDR_WIDTH'(i_d);
    ja = ADDR_WIDTH'(j_d);
    ka = ADDR_WIDTH'(k_d);
    nn = na * na;
  end

  // Output decode of the upcoming state, registered below
  always_comb begin
    addr_nx    = '0;
    mem_we_nx  = 1'b0;
    ar_we_nx   = 1'b0;
    br_we_nx   = 1'b0;
    acc_clr_nx = 1'b0;
    acc_we_nx  = 1'b0;
    done_nx    = 1'b0;
    busy_nx    = (state_d != S_IDLE);
    unique case (state_d)
      S_IDLE: ;
      S_CLR:  acc_clr_nx = 1'b1;
      S_FA:   addr_nx = ia * na + ka;
      S_FB: begin
        addr_nx  = nn + ka * na + ja;
        ar_we_nx = 1'b1;
      end
      S_LB:   br_we_nx  = 1'b1;
      S_MAC:  acc_we_nx = 1'b1;
      S_ST: begin
        addr_nx   = (nn << 1) + ia * na + ja;
        mem_we_nx = 1'b1;
      end
      S_DONE:  done_nx = 1'b1;
      default: ;
    endcase
  end

  // Glitch-free registered outputs, cleared at once by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
      mem_we   <= 1'b0;
      ar_we    <= 1'b0;
      br_we    <= 1'b0;
      acc_clr  <= 1'b0;
      acc_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      mem_addr <= addr_nx;
      mem_we   <= mem_we_nx;
      ar_we    <= ar_we_nx;
      br_we    <= br_we_nx;
      acc_clr  <= acc_clr_nx;
      acc_we   <= acc_we_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      err      <= err_nx;
    end
  end

endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Sequencing controller for the single-core matrix multiplier. It walks the i/j/k loops of an N×N product over a shared synchronous-read memory and drives the address bus, the memory write enable, and the write enables of the operand registers (A, B) and the accumulator. Datapath registers are plain clocked `we`-gated registers: they load `data_in` on the rising edge while `we` is high. The controller sits between the host start/done handshake and that datapath.

## Interface
- `ADDR_WIDTH`, 8: memory address width; must satisfy 3·MAX_DIM² ≤ 2^ADDR_WIDTH.
- `MAX_DIM`, 8: largest legal N.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: begin a multiply; sampled only in IDLE.
- `dim` in 4: N, latched when `start` is accepted.
- `mem_addr` out ADDR_WIDTH: memory address; read data is valid one cycle later.
- `mem_we` out 1: writes the accumulator output to `mem_addr`.
- `ar_we` out 1: load the A operand register from memory read data.
- `br_we` out 1: load the B operand register from memory read data.
- `acc_clr` out 1: synchronously clear the accumulator.
- `acc_we` out 1: accumulator ← accumulator + A·B.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: single-cycle completion pulse.
- `err` out 1: high with `done` only when `dim` was invalid.

## Operation
- Memory map, using latched N: A[i][k] at i·N+k; B[k][j] at N²+k·N+j; C[i][j] at 2N²+i·N+j. Addresses are computed at ADDR_WIDTH bits with no wrap. Parameter legality guarantees this.
- States:
  - IDLE: all outputs 0.
  - CLR: `acc_clr`=1.
  - FETCH_A: `mem_addr`=A addr.
  - FETCH_B: `mem_addr`=B addr, `ar_we`=1.
  - LATCH_B: `br_we`=1.
  - MAC: `acc_we`=1.
  - STORE: `mem_addr`=C addr, `mem_we`=1.
  - DONE: `done`=1.
- Transitions:
  - IDLE→CLR on `start` when 1 ≤ `dim` ≤ MAX_DIM.
  - IDLE→DONE on `start` with an invalid `dim`. `err` is then 1 in DONE.
  - CLR→FETCH_A→FETCH_B→LATCH_B→MAC.
  - MAC→FETCH_A with k+1 if k<N−1, else MAC→STORE.
  - STORE→CLR with the next (i,j) in row-major order, j fastest.
  - STORE→DONE after (N−1,N−1).
  - DONE→IDLE.
- Loop counters i, j, k are 4 bits. Each clears when it finishes; k clears on every STORE.
- `start` is ignored while `busy`=1. `dim` changes after acceptance have no effect.
- Outputs are registered-decode of state: they are valid in the state's cycle and glitch-free on the clock edge.

## Timing
- Reset: state IDLE, counters 0, and every output 0, including `mem_addr`. This is immediate on `rst` assertion, including mid-operation. No `done` is generated for an aborted job.
- `start` sampled high in IDLE at edge t gives CLR in cycle t+1.
- Cycles per output element: 4N+2.
- `done` is asserted N²(4N+2)+1 cycles after acceptance, counting CLR as cycle 1. N=1 → 7; N=2 → 41; N=4 → 289.
- Invalid `dim`: `done`=`err`=1 in the cycle after acceptance. There are no memory accesses.
- Back-to-back jobs: `start` may be held high. A new job is accepted on the IDLE cycle following DONE, so the minimum gap is 1 idle cycle.
- `busy` falls in the same cycle that the state returns to IDLE, i.e. one cycle after `done`.

## Configuration
- `MATMUL_CTRL_ABORT_EN` defined:
  - Adds an input `abort` (1 bit).
  - `abort`=1 in any busy state except DONE forces IDLE on the next edge.
  - No `done` is generated and no further `mem_we` occurs.
  - `abort` in IDLE or DONE has no effect.
- Macro not defined: the port is absent and jobs always run to completion.

## Test plan
- Reset values: assert `rst` mid-job (N=2, cycle 15). Required: all outputs 0 immediately, no `done` afterwards, and a fresh `start` is accepted normally.
- Functional multiply: behavioural memory plus register models, N=2, A=[1,2;3,4] at 0..3, B=[5,6;7,8] at 4..7. Required: C=[19,22;43,50] at 8..11, exactly 4 `mem_we` pulses, `done` in cycle 41.
- Smallest case: N=1, A=3, B=9. Required: 27 written to addr 2, `done` in cycle 7.
- Invalid dim: `start` with `dim`=0, then with `dim`=9. Required in each case: a `done`+`err` pulse the next cycle, with `mem_we`, `ar_we` and `acc_we` never asserted.
- Handshake:
  - Pulse `start` 3 times during a busy N=2 job. Required: a single job only, with `done` still in cycle 41.
  - Then hold `start` high. Required: the next job begins 1 cycle after `done`.
- With `MATMUL_CTRL_ABORT_EN`: assert `abort` in a MAC state of an N=2 job. Required: IDLE next cycle, no subsequent `mem_we`, no `done`.
